tdc_code_packer: RTL and testbench
==================================

Name: tdc_code_packer

Overview:
- Downstream consumer of the ring-oscillator TDC delay line. Takes the raw thermometer code captured on each measurement strobe and converts it to a binary tap count in a registered encoder stage.
- Results are buffered in a small FIFO. They are presented one byte at a time to the top-level uo_out bus, and read out by a host pulsing a ui_in pin.
- Lets slow off-chip readers collect bursts of measurements without losing samples.

Parameters:
- TAPS, 32, delay-line length (thermometer width); legal 2..63
- DEPTH, 8, FIFO entries; power of two, 2..16
- BIN_W, 6, binary code width; must satisfy 2**BIN_W > TAPS

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- tdc_valid  in  1  one-cycle strobe: tdc_therm holds a new capture
- tdc_therm  in  TAPS  thermometer code from delay-line flops; bit0 = first tap
- rd_req  in  1  host read request, already synchronised to clk; rising edge pops one entry
- ovf_clr  in  1  synchronous clear of the sticky overflow flag
- out_byte  out  8  head-of-FIFO entry: [7] = err, [6] = 0, [5:0] = code (zero-extended)
- out_valid  out  1  FIFO non-empty; out_byte is meaningful
- fifo_full  out  1  count == DEPTH
- overflow  out  1  sticky: a capture was dropped
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync deassert by the top level) clears:
  - all outputs to 0, including out_byte = 8'h00, out_valid = 0, fifo_count = 0, overflow = 0
  - FIFO pointers
  - the rd_req edge-detect register
- Encoder stage (1 cycle):
  - On tdc_valid, register code = popcount(tdc_therm), which is bubble tolerant.
  - Register err per the Optional Feature.
  - Raise an internal push strobe.
- Push: written into the FIFO on the cycle after the encoder register. tdc_valid at cycle N → out_valid/fifo_count updated at N+2.
- Pop: on the rd_req 0→1 transition (registered previous value), the FIFO advances when non-empty. out_byte reflects the new head on the following cycle. A held-high rd_req pops exactly once.
- Pop while empty: ignored. out_byte holds its last value, out_valid stays 0, and there is no error flag.
- Push while full with no simultaneous pop: sample dropped, overflow set, FIFO contents unchanged.
- Simultaneous push and pop:
  - Both are performed.
  - When full, the push is accepted and overflow is not set.
  - When empty, the pop is ignored and the push is accepted.
- Consecutive tdc_valid on every cycle is supported at full rate.
- ovf_clr and a new overflow in the same cycle: overflow remains set (set wins).
- Pointers wrap modulo DEPTH. fifo_count is explicit and never exceeds DEPTH.
- rst mid-operation discards the FIFO contents and any in-flight encoder result.

Optional Feature:
- Macro: TDC_BUBBLE_FLAG_EN
- Defined: err = 1 when tdc_therm is not a proper thermometer, i.e. any 0 followed by a 1 at a higher index. Detected in the same encoder cycle.
- Undefined: err is tied to 0, no check logic is synthesised, and out_byte[7] is always 0.

Decomposition:
- Shared package tdc_pkg holds:
  - TAPS and BIN_W defaults
  - the OUT_ERR_BIT = 7 constant
  - typedef tdc_entry_t {err, code[BIN_W-1:0]}
- One sub-module: tdc_therm2bin, a combinational popcount plus optional bubble check, with no registers.
- The FIFO and rd_req edge detect stay in the parent.

Test Plan:
- Reset, then tdc_therm = 32'h0000_00FF with tdc_valid at cycle N → out_valid = 1 at N+2, out_byte = 8'h08, fifo_count = 1; rising rd_req → out_valid = 0 next cycle.
- 10 back-to-back captures with codes 1..10, DEPTH = 8 → fifo_full = 1 after the 8th and overflow = 1 after the 9th. Reads return 8'h01..8'h08 in order; ovf_clr → overflow = 0.
- With FIFO full: push and rd_req rising edge in the same cycle → count stays 8, overflow stays 0, the newest code appears last.
- rd_req held high 20 cycles with 3 entries → exactly one pop; two rd_req pulses on an empty FIFO → no change, out_valid = 0.
- TDC_BUBBLE_FLAG_EN defined, tdc_therm = 32'h0000_00F7 → out_byte = 8'h87; without the macro → 8'h07.
- rst asserted asynchronously with 5 entries mid-stream → all outputs 0 immediately; first capture after release reads back correctly.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants and the FIFO entry type for the TDC code packer.
// The packed output byte is {err, 1'b0, code[5:0]}.
package tdc_pkg;

    localparam int TDC_TAPS    = 32;
    localparam int TDC_BIN_W   = 6;
    localparam int OUT_ERR_BIT = 7;

    typedef struct packed {
        logic                 err;
        logic [TDC_BIN_W-1:0] code;
    } tdc_entry_t;

    function automatic logic [7:0] pack_entry(input tdc_entry_t e);
        logic [7:0] b;
        b = '0;
        b[OUT_ERR_BIT] = e.err;
        b[TDC_BIN_W-1:0] = e.code;
        return b;
    endfunction

endpackage

// File: rtl/tdc_code_packer_if.sv
// Capture/readout bus of the TDC code packer; master = host/delay-line side,
// slave = the packer itself.
interface tdc_code_packer_if
    import tdc_pkg::*;
#(
    parameter int TAPS  = TDC_TAPS,
    parameter int DEPTH = 8
);

    logic                       tdc_valid;
    logic [TAPS-1:0]            tdc_therm;
    logic                       rd_req;
    logic                       ovf_clr;
    logic [7:0]                 out_byte;
    logic                       out_valid;
    logic                       fifo_full;
    logic                       overflow;
    logic [$clog2(DEPTH):0]     fifo_count;

    modport master (
        output tdc_valid, tdc_therm, rd_req, ovf_clr,
        input  out_byte, out_valid, fifo_full, overflow, fifo_count
    );

    modport slave (
        input  tdc_valid, tdc_therm, rd_req, ovf_clr,
        output out_byte, out_valid, fifo_full, overflow, fifo_count
    );

endinterface

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-binary converter (popcount, bubble tolerant).
// Bubble detection is built only when TDC_BUBBLE_FLAG_EN is defined.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int TAPS  = TDC_TAPS,
    parameter int BIN_W = TDC_BIN_W
) (
    input  logic [TAPS-1:0]  therm,
    output logic [BIN_W-1:0] code,
    output logic             err
);

    always_comb begin
        code = '0;
        for (int i = 0; i < TAPS; i++) begin
            code = code + BIN_W'(therm[i]);
        end
    end

`ifdef TDC_BUBBLE_FLAG_EN
    // Any 0 below a 1 implies at least one adjacent 0->1 step somewhere.
    logic [TAPS-2:0] step_up;
    genvar gi;
    generate
        for (gi = 0; gi < TAPS - 1; gi++) begin : g_bubble
            assign step_up[gi] = ~therm[gi] & therm[gi+1];
        end
    endgenerate
    assign err = |step_up;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/tdc_code_packer.sv
// TDC code packer: registered thermometer encoder feeding a small FIFO read
// out one byte per rd_req rising edge. Optional bubble flag: TDC_BUBBLE_FLAG_EN.
module tdc_code_packer
    import tdc_pkg::*;
#(
    parameter int TAPS  = TDC_TAPS,
    parameter int DEPTH = 8,
    parameter int BIN_W = TDC_BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    tdc_code_packer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [BIN_W-1:0] bin_code;
    logic             bin_err;

    tdc_therm2bin #(
        .TAPS  (TAPS),
        .BIN_W (BIN_W)
    ) u_therm2bin (
        .therm (bus.tdc_therm),
        .code  (bin_code),
        .err   (bin_err)
    );

    logic       enc_valid_reg;
    tdc_entry_t enc_entry_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_valid_reg <= 1'b0;
            enc_entry_reg <= '0;
        end else begin
            enc_valid_reg <= bus.tdc_valid;
            if (bus.tdc_valid) begin
                enc_entry_reg.err  <= bin_err;
                enc_entry_reg.code <= TDC_BIN_W'(bin_code);
            end
        end
    end

    tdc_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             rd_prev_reg;
    logic [7:0]       out_byte_reg;

    logic       rd_rise, empty, full, pop, push_ok, drop, bypass;
    tdc_entry_t head_next;

    always_comb begin
        rd_rise       = bus.rd_req & ~rd_prev_reg;
        empty         = (count_reg == '0);
        full          = (count_reg == CNT_W'(DEPTH));
        pop           = rd_rise & ~empty;
        push_ok       = enc_valid_reg & (~full | pop);
        drop          = enc_valid_reg & full & ~pop;
        rd_ptr_next   = pop     ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        wr_ptr_next   = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        count_next    = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
        overflow_next = drop | (overflow_reg & ~bus.ovf_clr);
        // The entry being written becomes the head when nothing else remains.
        bypass        = push_ok & (count_reg == CNT_W'(pop));
        head_next     = bypass ? enc_entry_reg : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= enc_entry_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_prev_reg  <= 1'b0;
            out_byte_reg <= 8'h00;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rd_prev_reg  <= bus.rd_req;
            // Once drained, the last presented byte is held.
            if (count_next != '0) begin
                out_byte_reg <= pack_entry(head_next);
            end
        end
    end

    assign bus.out_byte   = out_byte_reg;
    assign bus.out_valid  = (count_reg != '0);
    assign bus.fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign bus.overflow   = overflow_reg;
    assign bus.fifo_count = count_reg;

endmodule

// File: tb/tb_tdc_code_packer.sv
// Directed self-checking bench for tdc_code_packer (TAPS=32, DEPTH=8).
module tb_tdc_code_packer;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    tdc_code_packer_if #(.TAPS(32), .DEPTH(8)) bus ();

    tdc_code_packer #(.TAPS(32), .DEPTH(8), .BIN_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] v);
        bus.tdc_therm = v;
        bus.tdc_valid = 1'b1;
        step();
        bus.tdc_valid = 1'b0;
    endtask

    task automatic pulse_rd();
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        step();
    endtask

    function automatic logic [31:0] therm_of(input int n);
        logic [32:0] t;
        t = (33'd1 << n) - 33'd1;
        return t[31:0];
    endfunction

    task automatic test_reset();
        checks++;
        if ({bus.out_byte, bus.out_valid, bus.fifo_full, bus.overflow, bus.fifo_count} !== 16'h0)
            $display("FAIL reset_outputs: got byte=%h v=%b f=%b o=%b c=%0d, want all 0",
                     bus.out_byte, bus.out_valid, bus.fifo_full, bus.overflow, bus.fifo_count);
        else passes++;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 4'd0)
            $display("FAIL post_reset: got v=%b c=%0d, want 0/0", bus.out_valid, bus.fifo_count);
        else passes++;
    endtask

    task automatic test_single();
        capture(32'h0000_00FF);
        checks++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL single_latency_n1: got out_valid=%b, want 0", bus.out_valid);
        else passes++;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h08 || bus.fifo_count !== 4'd1)
            $display("FAIL single_n2: got v=%b byte=%h c=%0d, want 1/08/1",
                     bus.out_valid, bus.out_byte, bus.fifo_count);
        else passes++;
        bus.rd_req = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 4'd0)
            $display("FAIL single_pop: got v=%b c=%0d, want 0/0", bus.out_valid, bus.fifo_count);
        else passes++;
        bus.rd_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 10; k++) begin
            bus.tdc_therm = therm_of(k);
            bus.tdc_valid = 1'b1;
            step();
            if (k == 9) begin
                checks++;
                if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0 || bus.fifo_count !== 4'd8)
                    $display("FAIL b2b_full_after8: got f=%b o=%b c=%0d, want 1/0/8",
                             bus.fifo_full, bus.overflow, bus.fifo_count);
                else passes++;
            end
        end
        bus.tdc_valid = 1'b0;
        step();
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_count !== 4'd8)
            $display("FAIL b2b_overflow: got o=%b c=%0d, want 1/8", bus.overflow, bus.fifo_count);
        else passes++;
        step();
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.out_byte !== 8'(i) || bus.out_valid !== 1'b1)
                $display("FAIL b2b_read%0d: got byte=%h v=%b, want %h/1",
                         i, bus.out_byte, bus.out_valid, 8'(i));
            else passes++;
            pulse_rd();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1)
            $display("FAIL b2b_drained: got v=%b o=%b, want 0/1", bus.out_valid, bus.overflow);
        else passes++;
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0)
            $display("FAIL ovf_clr: got overflow=%b, want 0", bus.overflow);
        else passes++;
    endtask

    task automatic test_full_push_pop();
        for (int k = 1; k <= 8; k++) begin
            bus.tdc_therm = therm_of(k);
            bus.tdc_valid = 1'b1;
            step();
        end
        bus.tdc_valid = 1'b0;
        step();
        checks++;
        if (bus.fifo_count !== 4'd8)
            $display("FAIL fpp_fill: got count=%0d, want 8", bus.fifo_count);
        else passes++;
        capture(therm_of(20));
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        checks++;
        if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b0)
            $display("FAIL fpp_same_cycle: got c=%0d o=%b, want 8/0", bus.fifo_count, bus.overflow);
        else passes++;
        step();
        for (int i = 2; i <= 9; i++) begin
            logic [7:0] exp;
            exp = (i == 9) ? 8'h14 : 8'(i);
            checks++;
            if (bus.out_byte !== exp)
                $display("FAIL fpp_read%0d: got byte=%h, want %h", i, bus.out_byte, exp);
            else passes++;
            pulse_rd();
        end
    endtask

    task automatic test_held_and_empty();
        capture(therm_of(3));
        capture(therm_of(4));
        capture(therm_of(5));
        step();
        checks++;
        if (bus.fifo_count !== 4'd3)
            $display("FAIL held_fill: got count=%0d, want 3", bus.fifo_count);
        else passes++;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bus.fifo_count !== 4'd2 || bus.out_byte !== 8'h04)
            $display("FAIL held_once: got c=%0d byte=%h, want 2/04", bus.fifo_count, bus.out_byte);
        else passes++;
        bus.rd_req = 1'b0;
        step();
        pulse_rd();
        pulse_rd();
        pulse_rd();
        pulse_rd();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 4'd0 || bus.out_byte !== 8'h05)
            $display("FAIL empty_pop: got v=%b c=%0d byte=%h, want 0/0/05",
                     bus.out_valid, bus.fifo_count, bus.out_byte);
        else passes++;
    endtask

    task automatic test_bubble();
        logic [7:0] exp;
`ifdef TDC_BUBBLE_FLAG_EN
        exp = 8'h87;
`else
        exp = 8'h07;
`endif
        capture(32'h0000_00F7);
        step();
        checks++;
        if (bus.out_byte !== exp)
            $display("FAIL bubble: got byte=%h, want %h", bus.out_byte, exp);
        else passes++;
        pulse_rd();
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 5; k++) capture(therm_of(k + 10));
        step();
        checks++;
        if (bus.fifo_count !== 4'd5)
            $display("FAIL rstmid_fill: got count=%0d, want 5", bus.fifo_count);
        else passes++;
        bus.tdc_therm = therm_of(9);
        bus.tdc_valid = 1'b1;
        step();
        bus.tdc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_byte, bus.out_valid, bus.fifo_full, bus.overflow, bus.fifo_count} !== 16'h0)
            $display("FAIL rstmid_async: got byte=%h v=%b c=%0d, want all 0",
                     bus.out_byte, bus.out_valid, bus.fifo_count);
        else passes++;
        step();
        rst = 1'b0;
        step();
        capture(32'hFFFF_FFFF);
        step();
        checks++;
        if (bus.fifo_count !== 4'd1 || bus.out_byte !== 8'h20)
            $display("FAIL rstmid_after: got c=%0d byte=%h, want 1/20", bus.fifo_count, bus.out_byte);
        else passes++;
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        rst           = 1'b1;
        bus.tdc_valid = 1'b0;
        bus.tdc_therm = '0;
        bus.rd_req    = 1'b0;
        bus.ovf_clr   = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_push_pop();
        test_held_and_empty();
        test_bubble();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
